// File: rtl/ifft4_pkg.sv
// Shared definitions for the 4-point streaming inverse FFT: default width,
// inverse twiddle W4^-1 = +j, and the sequencing state encoding.
package ifft4_pkg;

   localparam int W_DEF = 16;

   // W4^-1 = e^(+j*pi/2) = 0 + 1j
   localparam int W4_INV1_RE = 0;
   localparam int W4_INV1_IM = 1;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_EMIT    = 2'd2
   } state_e;

endpackage

// File: rtl/ifft4_core.sv
// Combinational 4-point radix-2 inverse butterfly. Outputs carry two guard
// bits so the unscaled sums never overflow.
module ifft4_core
   import ifft4_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic signed [W-1:0] y_re_i [4],
   input  logic signed [W-1:0] y_im_i [4],
   output logic signed [W+1:0] x_re_o [4],
   output logic signed [W+1:0] x_im_o [4]
);

   localparam int WE = W + 2;
   localparam logic signed [WE-1:0] TW_RE = WE'(W4_INV1_RE);
   localparam logic signed [WE-1:0] TW_IM = WE'(W4_INV1_IM);

   logic signed [WE-1:0] e_re [4];
   logic signed [WE-1:0] e_im [4];
   logic signed [WE-1:0] s0_re, s0_im, s1_re, s1_im, s2_re, s2_im, s3_re, s3_im;
   logic signed [WE-1:0] t_re, t_im;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         e_re[i] = WE'(y_re_i[i]);
         e_im[i] = WE'(y_im_i[i]);
      end
      s0_re = e_re[0] + e_re[2];
      s0_im = e_im[0] + e_im[2];
      s1_re = e_re[0] - e_re[2];
      s1_im = e_im[0] - e_im[2];
      s2_re = e_re[1] + e_re[3];
      s2_im = e_im[1] + e_im[3];
      t_re  = e_re[1] - e_re[3];
      t_im  = e_im[1] - e_im[3];
      // constant twiddle multiply collapses to re=-t.im, im=t.re
      s3_re = TW_RE * t_re - TW_IM * t_im;
      s3_im = TW_RE * t_im + TW_IM * t_re;

      x_re_o[0] = s0_re + s2_re;
      x_im_o[0] = s0_im + s2_im;
      x_re_o[2] = s0_re - s2_re;
      x_im_o[2] = s0_im - s2_im;
      x_re_o[1] = s1_re + s3_re;
      x_im_o[1] = s1_im + s3_im;
      x_re_o[3] = s1_re - s3_re;
      x_im_o[3] = s1_im - s3_im;
   end

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse FFT: collects a 4-sample frame, transforms it in
// one cycle, then replays the 4 time-domain samples on a valid/ready output.
module ifft4_stream
   import ifft4_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter bit SCALE = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_re,
   input  logic signed [W-1:0] in_im,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_re,
   output logic signed [W-1:0] out_im,
   output logic [1:0]          out_idx,
   output logic                out_last,
   output logic                frame_err
);

   localparam int WE = W + 2;

   state_e state_q, state_d;
   logic [1:0] k_cnt_q, k_cnt_d;
   logic [1:0] n_cnt_q, n_cnt_d;
   logic       frame_err_q, frame_err_d;
   logic       in_fire, out_fire;

   logic signed [W-1:0]  buf_re_q [4];
   logic signed [W-1:0]  buf_im_q [4];
   logic signed [W-1:0]  res_re_q [4];
   logic signed [W-1:0]  res_im_q [4];
   logic signed [WE-1:0] x_re [4];
   logic signed [WE-1:0] x_im [4];
   logic signed [WE-1:0] sh_re [4];
   logic signed [WE-1:0] sh_im [4];
   logic                 unused_guard_bits;

   ifft4_core #(.W(W)) u_core (
      .y_re_i (buf_re_q),
      .y_im_i (buf_im_q),
      .x_re_o (x_re),
      .x_im_o (x_im)
   );

   // guard bits are dropped: after >>>2 they are pure sign, unscaled they wrap
   always_comb begin
      unused_guard_bits = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sh_re[i] = SCALE ? (x_re[i] >>> 2) : x_re[i];
         sh_im[i] = SCALE ? (x_im[i] >>> 2) : x_im[i];
         unused_guard_bits = unused_guard_bits ^ (^sh_re[i][WE-1:W]) ^ (^sh_im[i][WE-1:W]);
      end
   end

   assign in_ready  = (state_q == ST_COLLECT) && !reset;
   assign out_valid = (state_q == ST_EMIT);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign out_re    = res_re_q[n_cnt_q];
   assign out_im    = res_im_q[n_cnt_q];
   assign out_idx   = n_cnt_q;
   assign out_last  = (n_cnt_q == 2'd3);
   assign frame_err = frame_err_q;

   always_comb begin
      state_d     = state_q;
      k_cnt_d     = k_cnt_q;
      n_cnt_d     = n_cnt_q;
      frame_err_d = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (in_fire) begin
               if (k_cnt_q != 2'd3) begin
                  if (in_last) begin
                     frame_err_d = 1'b1;
                     k_cnt_d     = 2'd0;
                  end else begin
                     k_cnt_d = k_cnt_q + 2'd1;
                  end
               end else begin
                  frame_err_d = !in_last;
                  k_cnt_d     = 2'd0;
                  state_d     = ST_COMPUTE;
               end
            end
         end
         ST_COMPUTE: begin
            n_cnt_d = 2'd0;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (out_fire) begin
               n_cnt_d = n_cnt_q + 2'd1;
               if (n_cnt_q == 2'd3) begin
                  state_d = ST_COLLECT;
               end
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_COLLECT;
         k_cnt_q     <= '0;
         n_cnt_q     <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            buf_re_q[i] <= '0;
            buf_im_q[i] <= '0;
            res_re_q[i] <= '0;
            res_im_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         k_cnt_q     <= k_cnt_d;
         n_cnt_q     <= n_cnt_d;
         frame_err_q <= frame_err_d;
         if (in_fire) begin
            buf_re_q[k_cnt_q] <= in_re;
            buf_im_q[k_cnt_q] <= in_im;
         end
         if (state_q == ST_COMPUTE) begin
            for (int i = 0; i < 4; i++) begin
               res_re_q[i] <= sh_re[i][W-1:0];
               res_im_q[i] <= sh_im[i][W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_ifft4_stream.sv
// Self-checking bench for ifft4_stream: DFT-sum reference model, scoreboard
// compare on every output transfer, directed framing/backpressure/reset cases.
module tb_ifft4_stream;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_re = '0;
   logic signed [15:0] in_im = '0;
   logic               in_last = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;
   logic [1:0]         out_idx;
   logic               out_last;
   logic               frame_err;

   ifft4_stream dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {int re; int im; int idx;} exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int err_cnt = 0;
   int out_cnt = 0;
   int last_in_cyc = 0;
   bit bp_en = 1'b0;
   int bp_ph = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // multiply (re,im) by j^m
   function automatic void rot(input int m, input int re, input int im,
                               output int orr, output int oi);
      case (m & 3)
         0:       begin orr = re;  oi = im;  end
         1:       begin orr = -im; oi = re;  end
         2:       begin orr = -re; oi = -im; end
         default: begin orr = im;  oi = -re; end
      endcase
   endfunction

   function automatic void ifft_ref(input int yr[4], input int yi[4],
                                    output int xr[4], output int xi[4]);
      int a, b, sr, si;
      for (int n = 0; n < 4; n++) begin
         sr = 0; si = 0;
         for (int k = 0; k < 4; k++) begin
            rot(k * n, yr[k], yi[k], a, b);
            sr += a; si += b;
         end
         xr[n] = sr >>> 2;
         xi[n] = si >>> 2;
      end
   endfunction

   function automatic void fft_ref(input int xr[4], input int xi[4],
                                   output int yr[4], output int yi[4]);
      int a, b;
      for (int k = 0; k < 4; k++) begin
         yr[k] = 0; yi[k] = 0;
         for (int n = 0; n < 4; n++) begin
            rot(-(k * n), xr[n], xi[n], a, b);
            yr[k] += a; yi[k] += b;
         end
      end
   endfunction

   task automatic push_expected(input int yr[4], input int yi[4]);
      int xr[4], xi[4];
      ifft_ref(yr, yi, xr, xi);
      for (int n = 0; n < 4; n++) exp_q.push_back('{re: xr[n], im: xi[n], idx: n});
   endtask

   task automatic pin_model(input string name, input int yr[4], input int yi[4],
                            input int er[4], input int ei[4]);
      int xr[4], xi[4];
      ifft_ref(yr, yi, xr, xi);
      for (int n = 0; n < 4; n++) begin
         chk({name, "_re"}, xr[n], er[n]);
         chk({name, "_im"}, xi[n], ei[n]);
      end
   endtask

   task automatic send_sample(input int re, input int im, input bit last, output int when);
      int t;
      in_valid = 1'b1; in_re = 16'(re); in_im = 16'(im); in_last = last;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         t++;
         @(negedge clk);
      end
      chk("in_accept_timeout", int'(t < 100), 1);
      when = cyc;
      last_in_cyc = cyc;
      @(posedge clk); #1;
   endtask

   // last_pos: index carrying in_last; 4 means no in_last at all
   task automatic send_frame(input int yr[4], input int yi[4], input int last_pos,
                             input bit expect_out, output int first_cyc);
      int w, stop;
      stop = (last_pos < 3) ? last_pos : 3;
      first_cyc = 0;
      for (int s = 0; s <= stop; s++) begin
         send_sample(yr[s], yi[s], s == last_pos, w);
         if (s == 0) first_cyc = w;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (expect_out) push_expected(yr, yi);
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_timeout", int'(t < 300), 1);
   endtask

   always @(posedge clk) begin
      #1;
      if (bp_en) begin
         out_ready = (bp_ph == 0);
         bp_ph = (bp_ph + 1) % 3;
      end else begin
         out_ready = 1'b1;
         bp_ph = 0;
      end
   end

   // scoreboard / protocol monitor
   bit stall_hold = 1'b0;
   bit prev_valid = 1'b0;
   int h_re, h_im, h_idx, h_last;
   always @(negedge clk) begin
      if (reset) begin
         stall_hold = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (frame_err) err_cnt++;
         if (exp_q.size() != 0) chk("in_ready_blocked", int'(in_ready), 0);
         if (out_valid && !prev_valid) chk("latency", cyc - last_in_cyc, 2);
         if (stall_hold) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_re", int'(out_re), h_re);
            chk("stall_im", int'(out_im), h_im);
            chk("stall_idx", int'(out_idx), h_idx);
            chk("stall_last", int'(out_last), h_last);
         end
         stall_hold = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", int'(out_valid), 0);
               end else begin
                  chk("out_re", int'(out_re), exp_q[0].re);
                  chk("out_im", int'(out_im), exp_q[0].im);
                  chk("out_idx", int'(out_idx), exp_q[0].idx);
                  chk("out_last", int'(out_last), int'(exp_q[0].idx == 3));
                  void'(exp_q.pop_front());
                  out_cnt++;
               end
            end else begin
               stall_hold = 1'b1;
               h_re = int'(out_re); h_im = int'(out_im);
               h_idx = int'(out_idx); h_last = int'(out_last);
            end
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int yr[4], yi[4], er[4], ei[4], xr[4], xi[4], mr[4], mi[4];
      int ta, tb, e0, o0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_re", int'(out_re), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      // 1: DC impulse
      yr = '{4, 0, 0, 0}; yi = '{0, 0, 0, 0};
      er = '{1, 1, 1, 1}; ei = '{0, 0, 0, 0};
      pin_model("pin_dc", yr, yi, er, ei);
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();

      // 2: single tone, sign of the +j twiddle
      yr = '{0, 4, 0, 0}; yi = '{0, 0, 0, 0};
      er = '{1, 0, -1, 0}; ei = '{0, 1, 0, -1};
      pin_model("pin_tone", yr, yi, er, ei);
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();

      // 3: floor rounding and full-scale input
      yr = '{-1, 0, 0, 0}; yi = '{0, 0, 0, 0};
      er = '{-1, -1, -1, -1}; ei = '{0, 0, 0, 0};
      pin_model("pin_floor", yr, yi, er, ei);
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();
      yr = '{32767, 32767, 32767, 32767}; yi = '{32767, 32767, 32767, 32767};
      er = '{32767, 0, 0, 0}; ei = '{32767, 0, 0, 0};
      pin_model("pin_full", yr, yi, er, ei);
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();
      yr = '{-32768, 32767, -32768, 32767}; yi = '{32767, -32768, -32768, 32767};
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();

      // 4a: output backpressure 1,0,0 pattern
      bp_en = 1'b1;
      yr = '{100, -37, 12, 5}; yi = '{-8, 21, 3, -77};
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();
      bp_en = 1'b0;
      @(posedge clk); #1;

      // 4b: back-to-back frames, 9-cycle period
      yr = '{7, 3, -2, 9}; yi = '{1, -4, 6, 0};
      send_frame(yr, yi, 3, 1'b1, ta);
      yr = '{-50, 20, 30, -40}; yi = '{11, 22, -33, 44};
      send_frame(yr, yi, 3, 1'b1, tb);
      chk("frame_period", tb - ta, 9);
      wait_drain();

      // 5: early in_last drops partial frame
      e0 = err_cnt; o0 = out_cnt;
      yr = '{9, 9, 9, 9}; yi = '{9, 9, 9, 9};
      send_frame(yr, yi, 1, 1'b0, ta);
      repeat (8) @(posedge clk);
      #1;
      chk("early_last_err", err_cnt - e0, 1);
      chk("early_last_no_out", out_cnt - o0, 0);
      yr = '{16, 0, -16, 8}; yi = '{4, -4, 0, 12};
      send_frame(yr, yi, 3, 1'b1, ta);
      wait_drain();
      chk("recover_out_cnt", out_cnt - o0, 4);

      // missing in_last at k=3: flagged but processed
      e0 = err_cnt;
      yr = '{2, 6, 10, 14}; yi = '{-3, 5, -7, 9};
      send_frame(yr, yi, 4, 1'b1, ta);
      wait_drain();
      chk("missing_last_err", err_cnt - e0, 1);

      // 6: reset during EMIT after two outputs
      o0 = out_cnt;
      yr = '{40, 8, -12, 4}; yi = '{0, 16, 4, -8};
      send_frame(yr, yi, 3, 1'b1, ta);
      begin
         int t = 0;
         while (out_cnt - o0 < 2 && t < 50) begin
            @(posedge clk); #2;
            t++;
         end
         chk("emit_two_timeout", int'(t < 50), 1);
      end
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_out_idx", int'(out_idx), 0);
      chk("mid_rst_out_re", int'(out_re), 0);
      repeat (6) @(posedge clk);
      #1;
      chk("mid_rst_no_resume", int'(out_valid), 0);

      // round trip: FFT in the bench, IFFT in the DUT
      for (int r = 0; r < 6; r++) begin
         for (int n = 0; n < 4; n++) begin
            xr[n] = int'($urandom_range(16000)) - 8000;
            xi[n] = int'($urandom_range(16000)) - 8000;
         end
         fft_ref(xr, xi, yr, yi);
         ifft_ref(yr, yi, mr, mi);
         for (int n = 0; n < 4; n++) begin
            chk("roundtrip_re_err", int'((mr[n] - xr[n]) <= 1 && (xr[n] - mr[n]) <= 1), 1);
            chk("roundtrip_im_err", int'((mi[n] - xi[n]) <= 1 && (xi[n] - mi[n]) <= 1), 1);
         end
         send_frame(yr, yi, 3, 1'b1, ta);
      end
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
